// File: rtl/digital_clock_core.sv
// 24-hour HH:MM:SS timekeeper with set modes, keys and active-low 7-segment outputs.
// Optional BLINK_EN: blanks the digits of the field being set while clk1 is low.
module digital_clock_core #(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MOD    = 24
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       clk1,
    input  logic       K0,
    input  logic       K1,
    input  logic       K2,
    input  logic       K3,
    input  logic       trans,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic [5:0] count_dis_s,
    output logic [5:0] count_dis_m,
    output logic [5:0] count_dis_h,
    output logic [6:0] state7,
    output logic       c1s,
    output logic       c0s,
    output logic       c1m,
    output logic       c0m,
    output logic       c1h,
    output logic       c0h,
    output logic       equal60_min,
    output logic       equal60
);

    localparam logic [1:0] MODE_NORMAL   = 2'd0;
    localparam logic [1:0] MODE_SET_SEC  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [1:0] MODE_SET_HOUR = 2'd3;

    localparam logic [5:0] SEC_LAST  = 6'd59;
    localparam logic [5:0] HOUR_LAST = 6'(HOUR_MOD - 1);

    // Raw input bundle {trans, clk1, K3, K2, K1, K0}; idle levels are the reset values
    // so no edge is seen when reset releases with keys up.
    localparam logic [5:0] SYNC_IDLE = 6'b00_1111;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [5:0] raw_in;
    logic [5:0] sync_q [SYNC_STAGES];
    logic [5:0] prev_q;
    logic [5:0] sync_out;

    assign raw_in   = {trans, clk1, K3, K2, K1, K0};
    assign sync_out = sync_q[SYNC_STAGES-1];

    // NOTE: every synchronizer stage is reset; these are flops, not a RAM, so a reset costs nothing and avoids X edges.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
            prev_q <= SYNC_IDLE;
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_out;
        end
    end

    logic k0_ev, k1_ev, k2_ev, k3_ev, tick_ev, trans_ev, clk1_s;

    assign k0_ev    = prev_q[0] & ~sync_out[0];
    assign k1_ev    = prev_q[1] & ~sync_out[1];
    assign k2_ev    = prev_q[2] & ~sync_out[2];
    assign k3_ev    = prev_q[3] & ~sync_out[3];
    assign tick_ev  = ~prev_q[4] & sync_out[4];
    assign trans_ev = ~prev_q[5] & sync_out[5];
    assign clk1_s   = sync_out[4];

    // ------------------------------------------------------------------
    // Time-keeping state
    // ------------------------------------------------------------------
    logic [5:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [1:0] mode_q, mode_d;
    logic       pend_q, pend_d;
    logic       wrap_s_q, wrap_s_d, wrap_m_q, wrap_m_d;
    logic       key_any, tick_any, sec_run, min_run, hour_run;

    assign key_any  = k0_ev | k1_ev | k2_ev | k3_ev;
    assign tick_any = tick_ev | pend_q;
    assign sec_run  = (mode_q != MODE_SET_SEC);
    assign min_run  = (mode_q == MODE_NORMAL) || (mode_q == MODE_SET_HOUR);
    assign hour_run = (mode_q == MODE_NORMAL);

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        mode_d   = mode_q;
        pend_d   = 1'b0;
        wrap_s_d = 1'b0;
        wrap_m_d = 1'b0;

        if (trans_ev) mode_d = mode_q + 2'd1;

        if (k3_ev) begin
            sec_d  = (sec_q  == '0) ? SEC_LAST  : sec_q  - 6'd1;
            min_d  = (min_q  == '0) ? SEC_LAST  : min_q  - 6'd1;
            hour_d = (hour_q == '0) ? HOUR_LAST : hour_q - 6'd1;
        end else begin
            if (k0_ev) sec_d  = (sec_q  == SEC_LAST)  ? '0 : sec_q  + 6'd1;
            if (k1_ev) min_d  = (min_q  == SEC_LAST)  ? '0 : min_q  + 6'd1;
            if (k2_ev) hour_d = (hour_q == HOUR_LAST) ? '0 : hour_q + 6'd1;
        end

        // A key owns this cycle; a coincident tick waits one cycle.
        if (key_any) begin
            pend_d = tick_any;
        end else if (tick_any && sec_run) begin
            if (sec_q == SEC_LAST) begin
                sec_d    = '0;
                wrap_s_d = 1'b1;
                if (min_run) begin
                    if (min_q == SEC_LAST) begin
                        min_d    = '0;
                        wrap_m_d = 1'b1;
                        if (hour_run) hour_d = (hour_q == HOUR_LAST) ? '0 : hour_q + 6'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sec_q    <= '0;
            min_q    <= '0;
            hour_q   <= '0;
            mode_q   <= MODE_NORMAL;
            pend_q   <= 1'b0;
            wrap_s_q <= 1'b0;
            wrap_m_q <= 1'b0;
        end else begin
            sec_q    <= sec_d;
            min_q    <= min_d;
            hour_q   <= hour_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            wrap_s_q <= wrap_s_d;
            wrap_m_q <= wrap_m_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered display and debug outputs
    // ------------------------------------------------------------------
    logic       blank_s, blank_m, blank_h;
    logic [6:0] hex0_d, hex1_d, hex2_d, hex3_d, hex4_d, hex5_d;

`ifdef BLINK_EN
    assign blank_s = (mode_q == MODE_SET_SEC)  && !clk1_s;
    assign blank_m = (mode_q == MODE_SET_MIN)  && !clk1_s;
    assign blank_h = (mode_q == MODE_SET_HOUR) && !clk1_s;
`else
    assign blank_s = 1'b0;
    assign blank_m = 1'b0;
    assign blank_h = 1'b0;
`endif

    always_comb begin
        hex0_d = blank_s ? 7'h7F : seg7(4'(sec_q  % 6'd10));
        hex1_d = blank_s ? 7'h7F : seg7(4'(sec_q  / 6'd10));
        hex2_d = blank_m ? 7'h7F : seg7(4'(min_q  % 6'd10));
        hex3_d = blank_m ? 7'h7F : seg7(4'(min_q  / 6'd10));
        hex4_d = blank_h ? 7'h7F : seg7(4'(hour_q % 6'd10));
        hex5_d = blank_h ? 7'h7F : seg7(4'(hour_q / 6'd10));
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            HEX0        <= 7'b1000000;
            HEX1        <= 7'b1000000;
            HEX2        <= 7'b1000000;
            HEX3        <= 7'b1000000;
            HEX4        <= 7'b1000000;
            HEX5        <= 7'b1000000;
            state7      <= 7'b1000000;
            count_dis_s <= '0;
            count_dis_m <= '0;
            count_dis_h <= '0;
            c1s         <= 1'b0;
            c0s         <= 1'b0;
            c1m         <= 1'b0;
            c0m         <= 1'b0;
            c1h         <= 1'b0;
            c0h         <= 1'b0;
            equal60     <= 1'b0;
            equal60_min <= 1'b0;
        end else begin
            HEX0        <= hex0_d;
            HEX1        <= hex1_d;
            HEX2        <= hex2_d;
            HEX3        <= hex3_d;
            HEX4        <= hex4_d;
            HEX5        <= hex5_d;
            state7      <= seg7({2'b00, mode_q});
            count_dis_s <= sec_q;
            count_dis_m <= min_q;
            count_dis_h <= hour_q;
            c1s         <= (sec_q == SEC_LAST);
            c0s         <= (sec_q % 6'd10) == 6'd9;
            c1m         <= (min_q == SEC_LAST);
            c0m         <= (min_q % 6'd10) == 6'd9;
            c1h         <= (hour_q == HOUR_LAST);
            c0h         <= (hour_q % 6'd10) == 6'd9;
            equal60     <= wrap_s_q;
            equal60_min <= wrap_m_q;
        end
    end

endmodule

// File: tb/tb_digital_clock_core.sv
// Directed self-checking bench for digital_clock_core (default build, BLINK_EN undefined).
module tb_digital_clock_core;

    logic       clk = 1'b0;
    logic       reset, clk1, K0, K1, K2, K3, trans;
    logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, state7;
    logic [5:0] count_dis_s, count_dis_m, count_dis_h;
    logic       c1s, c0s, c1m, c0m, c1h, c0h, equal60_min, equal60;

    int n_checks = 0;
    int n_fail   = 0;
    int e60_cnt  = 0;
    int e60m_cnt = 0;
    int e60_base, e60m_base;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG2 = 7'b0100100;
    localparam logic [6:0] SEG3 = 7'b0110000;
    localparam logic [6:0] SEG5 = 7'b0010010;
    localparam logic [6:0] SEG9 = 7'b0010000;

    digital_clock_core #(.SYNC_STAGES(2), .HOUR_MOD(24)) dut (
        .CLOCK_50(clk), .reset(reset), .clk1(clk1),
        .K0(K0), .K1(K1), .K2(K2), .K3(K3), .trans(trans),
        .HEX5(HEX5), .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
        .count_dis_s(count_dis_s), .count_dis_m(count_dis_m), .count_dis_h(count_dis_h),
        .state7(state7), .c1s(c1s), .c0s(c0s), .c1m(c1m), .c0m(c0m), .c1h(c1h), .c0h(c0h),
        .equal60_min(equal60_min), .equal60(equal60)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (equal60 === 1'b1) e60_cnt++;
        if (equal60_min === 1'b1) e60m_cnt++;
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk) clk1 = 1'b1;
        cyc(6);
        clk1 = 1'b0;
        cyc(6);
    endtask

    task automatic press(input int key);
        @(negedge clk);
        case (key)
            0: K0 = 1'b0;
            1: K1 = 1'b0;
            2: K2 = 1'b0;
            default: K3 = 1'b0;
        endcase
        cyc(4);
        {K3, K2, K1, K0} = 4'b1111;
        cyc(4);
    endtask

    task automatic mode_step();
        @(negedge clk) trans = 1'b1;
        cyc(5);
        trans = 1'b0;
        cyc(5);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(3);
    endtask

    task automatic snap();
        e60_base  = e60_cnt;
        e60m_base = e60m_cnt;
    endtask

    initial begin
        reset = 1'b1; clk1 = 1'b0; trans = 1'b0;
        {K3, K2, K1, K0} = 4'b1111;
        cyc(3);
        check("rst_sec", count_dis_s, 0);
        check("rst_hex0", HEX0, SEG0);
        check("rst_hex5", HEX5, SEG0);
        check("rst_state7", state7, SEG0);
        check("rst_c1s", c1s, 0);
        check("rst_eq60", equal60, 0);
        reset = 1'b0;
        cyc(3);

        // Three ticks in NORMAL
        snap();
        repeat (3) tick();
        check("t3_sec", count_dis_s, 3);
        check("t3_hex0", HEX0, SEG3);
        check("t3_hex1", HEX1, SEG0);
        check("t3_state7", state7, SEG0);
        check("t3_no_eq60", e60_cnt - e60_base, 0);

        // K3 from 00:00:00 wraps to 23:59:59 without pulses, then a tick rolls everything over
        do_reset();
        check("rst2_sec", count_dis_s, 0);
        snap();
        press(3);
        check("k3_sec", count_dis_s, 59);
        check("k3_min", count_dis_m, 59);
        check("k3_hour", count_dis_h, 23);
        check("k3_hex5", HEX5, SEG2);
        check("k3_hex4", HEX4, SEG3);
        check("k3_c1h", c1h, 1);
        check("k3_c0h", c0h, 0);
        check("k3_c0s", c0s, 1);
        check("k3_no_pulse", (e60_cnt - e60_base) + (e60m_cnt - e60m_base), 0);
        snap();
        tick();
        check("roll_sec", count_dis_s, 0);
        check("roll_min", count_dis_m, 0);
        check("roll_hour", count_dis_h, 0);
        check("roll_eq60", e60_cnt - e60_base, 1);
        check("roll_eq60m", e60m_cnt - e60m_base, 1);

        // Preset 00:00:59 via K3 (23:59:59), K1 (23:00:59), K2 (00:00:59)
        press(3); press(1); press(2);
        check("pre_sec", count_dis_s, 59);
        check("pre_min", count_dis_m, 0);
        check("pre_hour", count_dis_h, 0);
        check("pre_c1s", c1s, 1);
        check("pre_c1m", c1m, 0);
        snap();
        tick();
        check("s59_sec", count_dis_s, 0);
        check("s59_min", count_dis_m, 1);
        check("s59_eq60", e60_cnt - e60_base, 1);
        check("s59_eq60m", e60m_cnt - e60m_base, 0);

        // SET_SEC: whole clock frozen, K0 still works
        mode_step();
        check("ss_state7", state7, SEG1);
        press(0);
        repeat (5) tick();
        check("ss_sec", count_dis_s, 1);
        check("ss_min", count_dis_m, 1);
        repeat (3) mode_step();
        check("ss_back_state7", state7, SEG0);
        tick();
        check("ss_resume_sec", count_dis_s, 2);

        // SET_MIN at 00:05:58: seconds run, minutes absorb the carry
        repeat (4) press(1);
        repeat (56) press(0);
        check("sm_pre_min", count_dis_m, 5);
        check("sm_pre_sec", count_dis_s, 58);
        mode_step(); mode_step();
        check("sm_state7", state7, SEG2);
        snap();
        repeat (3) tick();
        check("sm_sec", count_dis_s, 1);
        check("sm_min", count_dis_m, 5);
        check("sm_hour", count_dis_h, 0);
        check("sm_no_eq60m", e60m_cnt - e60m_base, 0);

        // Reset mid-operation clears mode and counters; first tick counts
        do_reset();
        check("mid_rst_state7", state7, SEG0);
        check("mid_rst_min", count_dis_m, 0);
        tick();
        check("post_rst_sec", count_dis_s, 1);

        // K1 sixty times wraps minutes without carry or pulses
        snap();
        repeat (60) press(1);
        check("k1x60_min", count_dis_m, 0);
        check("k1x60_hour", count_dis_h, 0);
        check("k1x60_no_pulse", e60m_cnt - e60m_base, 0);
        press(1);
        check("k1_hex2", HEX2, SEG1);

        // K1 and tick in the same cycle: both applied
        @(negedge clk) begin clk1 = 1'b1; K1 = 1'b0; end
        cyc(6);
        clk1 = 1'b0; K1 = 1'b1;
        cyc(6);
        check("coinc_min", count_dis_m, 2);
        check("coinc_sec", count_dis_s, 2);

        // Simultaneous K0/K1/K2 each act on their own field
        @(negedge clk) {K2, K1, K0} = 3'b000;
        cyc(4);
        {K2, K1, K0} = 3'b111;
        cyc(4);
        check("multi_sec", count_dis_s, 3);
        check("multi_min", count_dis_m, 3);
        check("multi_hour", count_dis_h, 1);

        // K2 wraps hours 23 -> 0 and seconds units 9 drives c0s
        repeat (22) press(2);
        check("h23_c1h", c1h, 1);
        press(2);
        check("hwrap_hour", count_dis_h, 0);
        repeat (6) press(0);
        check("s9_hex0", HEX0, SEG9);
        check("s9_c0s", c0s, 1);
        repeat (46) press(0);
        check("s55_hex1", HEX1, SEG5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
